// File: rtl/rx_crc_a_checker.sv
// CRC_A checker on the PCD->PICC receive path: holds back the last two full bytes,
// strips them when the CRC_A residue is zero, otherwise flushes every byte unmodified.
module rx_crc_a_checker #(
    parameter logic [15:0] CRC_INIT = 16'h6363
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic [7:0] in_data,
    input  logic       in_data_valid,
    input  logic [2:0] in_data_bits,
    input  logic       in_error,
    output logic       out_soc,
    output logic       out_eoc,
    output logic [7:0] out_data,
    output logic       out_data_valid,
    output logic [2:0] out_data_bits,
    output logic       out_error,
    output logic       out_crc_ok,
    output logic [1:0] state_dbg
);

    // Handshake: in_data_valid qualifies in_data/in_data_bits for exactly one cycle;
    // there is no ready/backpressure in either direction, out_data_valid is a 1-cycle pulse.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RX    = 2'd1,
        S_FLUSH = 2'd2,
        S_EOC   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]  hb0, hb1, tail_data;
    logic [2:0]  tail_bits;
    logic        tail_vld, err_r;
    logic [1:0]  held, cnt;
    logic [15:0] crc;

    logic [7:0]  hb0_n, hb1_n, tail_data_n;
    logic [2:0]  tail_bits_n;
    logic        tail_vld_n, err_n;
    logic [1:0]  held_n, cnt_n;
    logic [15:0] crc_n;

    logic        soc_n, eoc_n, dv_n, ok_n, errout_n;
    logic [7:0]  data_n;
    logic [2:0]  bits_n;
    logic        do_pop;

    logic crc_good;
    logic has_entry;

    function automatic logic [15:0] crc_a_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    // A residue of zero over data+CRC means the trailing two bytes were a valid CRC_A.
    assign crc_good  = !in_error && !tail_vld && (cnt == 2'd3) && (crc == 16'h0000);
    assign has_entry = (held != 2'd0) || tail_vld;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (in_soc) begin
            state_nxt = S_RX;
        end else begin
            case (state)
                S_RX: begin
                    if (in_eoc) begin
                        state_nxt = (crc_good || !has_entry) ? S_EOC : S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!has_entry) state_nxt = S_EOC;
                end
                S_EOC:   state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Outputs are registered with the transition that enters a state, so out_eoc
    // rises on the same edge the FSM moves into EOC.
    always_comb begin
        hb0_n       = hb0;
        hb1_n       = hb1;
        tail_data_n = tail_data;
        tail_bits_n = tail_bits;
        tail_vld_n  = tail_vld;
        err_n       = err_r;
        held_n      = held;
        cnt_n       = cnt;
        crc_n       = crc;
        soc_n       = 1'b0;
        eoc_n       = 1'b0;
        dv_n        = 1'b0;
        ok_n        = 1'b0;
        errout_n    = 1'b0;
        data_n      = out_data;
        bits_n      = out_data_bits;
        do_pop      = 1'b0;

        if (in_soc) begin
            soc_n      = 1'b1;
            held_n     = 2'd0;
            cnt_n      = 2'd0;
            tail_vld_n = 1'b0;
            crc_n      = CRC_INIT;
            err_n      = 1'b0;
        end else begin
            case (state)
                S_RX: begin
                    if (in_eoc) begin
                        err_n = in_error;
                        if (crc_good) begin
                            eoc_n      = 1'b1;
                            ok_n       = 1'b1;
                            held_n     = 2'd0;
                            tail_vld_n = 1'b0;
                        end else if (!has_entry) begin
                            eoc_n    = 1'b1;
                            errout_n = in_error;
                        end else begin
                            do_pop = 1'b1;
                        end
                    end else if (in_data_valid) begin
                        if (in_data_bits == 3'd0) begin
                            crc_n = crc_a_byte(crc, in_data);
                            cnt_n = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
                            case (held)
                                2'd2: begin
                                    dv_n   = 1'b1;
                                    data_n = hb0;
                                    bits_n = 3'd0;
                                    hb0_n  = hb1;
                                    hb1_n  = in_data;
                                end
                                2'd1: begin
                                    hb1_n  = in_data;
                                    held_n = 2'd2;
                                end
                                default: begin
                                    hb0_n  = in_data;
                                    held_n = 2'd1;
                                end
                            endcase
                        end else begin
                            tail_data_n = in_data;
                            tail_bits_n = in_data_bits;
                            tail_vld_n  = 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (has_entry) begin
                        do_pop = 1'b1;
                    end else begin
                        eoc_n    = 1'b1;
                        errout_n = err_r;
                    end
                end
                default: ;
            endcase
        end

        // Held bytes leave in arrival order before the partial tail.
        if (do_pop) begin
            dv_n = 1'b1;
            if (held != 2'd0) begin
                data_n = hb0;
                bits_n = 3'd0;
                hb0_n  = hb1;
                held_n = held - 2'd1;
            end else begin
                data_n     = tail_data;
                bits_n     = tail_bits;
                tail_vld_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb0            <= 8'h00;
            hb1            <= 8'h00;
            tail_data      <= 8'h00;
            tail_bits      <= 3'd0;
            tail_vld       <= 1'b0;
            err_r          <= 1'b0;
            held           <= 2'd0;
            cnt            <= 2'd0;
            crc            <= CRC_INIT;
            out_soc        <= 1'b0;
            out_eoc        <= 1'b0;
            out_data       <= 8'h00;
            out_data_valid <= 1'b0;
            out_data_bits  <= 3'd0;
            out_error      <= 1'b0;
            out_crc_ok     <= 1'b0;
        end else begin
            hb0            <= hb0_n;
            hb1            <= hb1_n;
            tail_data      <= tail_data_n;
            tail_bits      <= tail_bits_n;
            tail_vld       <= tail_vld_n;
            err_r          <= err_n;
            held           <= held_n;
            cnt            <= cnt_n;
            crc            <= crc_n;
            out_soc        <= soc_n;
            out_eoc        <= eoc_n;
            out_data       <= data_n;
            out_data_valid <= dv_n;
            out_data_bits  <= bits_n;
            out_error      <= errout_n;
            out_crc_ok     <= ok_n;
        end
    end

endmodule
